// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 4x4 multiply sequencer around a single 4-bit ripple ALU.
// Define ALU_SEQ_DIV_EN to add restoring division (op=1) with a divide-by-zero flag.
module alu_mul_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       err
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] m_q, m_d;
  logic [3:0] q_q, q_d;
  logic [3:0] acc_q, acc_d;
  logic [7:0] result_q, result_d;
  logic       done_q, done_d;

  // ALU_4Bit: sel 00 = A+B+Cin, 01 = A+~B+Cin, 10 = A+Cin
  logic [3:0] alu_a, alu_b, alu_d, alu_bop;
  logic [1:0] alu_sel;
  logic       alu_cin, alu_cout, alu_carry;

`ifdef ALU_SEQ_DIV_EN
  logic       op_q, op_d;
  logic       err_q, err_d;
  logic       div_ov;
  logic [3:0] div_r, div_qs;
`else
  logic unused_op;
  assign unused_op = op;
`endif

  // Operand and select steering; depends only on registered state.
  always_comb begin
    alu_a   = acc_q;
    alu_b   = m_q;
    alu_sel = q_q[0] ? 2'b00 : 2'b10;
    alu_cin = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    div_ov = acc_q[3];
    div_r  = {acc_q[2:0], q_q[3]};
    div_qs = {q_q[2:0], 1'b0};
    if (op_q) begin
      alu_a   = div_r;
      alu_sel = 2'b01;
      alu_cin = 1'b1;
    end
`endif
  end

  always_comb begin
    unique case (alu_sel)
      2'b00:   alu_bop = alu_b;
      2'b01:   alu_bop = ~alu_b;
      default: alu_bop = 4'h0;
    endcase
    alu_d     = 4'h0;
    alu_carry = alu_cin;
    for (int i = 0; i < 4; i++) begin
      alu_d[i]  = alu_a[i] ^ alu_bop[i] ^ alu_carry;
      alu_carry = (alu_a[i] & alu_bop[i]) | (alu_carry & (alu_a[i] ^ alu_bop[i]));
    end
    alu_cout = alu_carry;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    m_d      = m_q;
    q_d      = q_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    op_d  = op_q;
    err_d = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIter;
          m_d     = a;
          q_d     = b;
          acc_d   = 4'h0;
          cnt_d   = 2'd0;
`ifdef ALU_SEQ_DIV_EN
          op_d    = op;
`endif
        end
      end
      StIter: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = StDone;
        end
        // With sel=10 the ALU passes acc through, so {Cout,D} is sum5 in both cases.
        acc_d = {alu_cout, alu_d[3:1]};
        q_d   = {alu_d[0], q_q[3:1]};
`ifdef ALU_SEQ_DIV_EN
        if (op_q) begin
          if (div_ov | alu_cout) begin
            acc_d = alu_d;
            q_d   = div_qs | 4'h1;
          end else begin
            acc_d = div_r;
            q_d   = div_qs;
          end
        end
`endif
      end
      StDone: begin
        state_d  = StIdle;
        done_d   = 1'b1;
        result_d = {acc_q, q_q};
`ifdef ALU_SEQ_DIV_EN
        err_d    = op_q & (m_q == 4'h0);
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      m_q      <= 4'h0;
      q_q      <= 4'h0;
      acc_q    <= 4'h0;
      result_q <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      m_q      <= m_d;
      q_q      <= q_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_SEQ_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule
